// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - N-to-1 AXI-Stream packet arbiter with header latch and beat watchdog
//
// Grants the output to one input channel per packet and holds that grant
// until the TLAST beat (or until the beat watchdog cuts a runaway packet).
// The destination coordinates are captured from the header flit at grant time.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_tdata/s_tvalid/
//   s_tlast/s_tready      per-channel input streams, channel i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_tdata/m_tvalid/
//   m_tlast/m_tready      muxed output stream
//   target_x/target_y     header coordinates of the current packet
//   grant                 one-hot owner, zero while idle
//   wdog_err              one-cycle pulse after a watchdog-terminated beat

module axis_packet_arbiter #(
   parameter int CHANNEL_NUMBER = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_ROUTERS_X  = 4,
   parameter int MAX_ROUTERS_Y  = 4,
   parameter int ARB_MODE       = 0,
   parameter int MAX_PKT_BEATS  = 64,
   localparam int XW = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1,
   localparam int YW = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] s_tdata,
   input  logic [CHANNEL_NUMBER-1:0]            s_tvalid,
   input  logic [CHANNEL_NUMBER-1:0]            s_tlast,
   output logic [CHANNEL_NUMBER-1:0]            s_tready,
   output logic [DATA_WIDTH-1:0]                m_tdata,
   output logic                                 m_tvalid,
   output logic                                 m_tlast,
   input  logic                                 m_tready,
   output logic [XW-1:0]                        target_x,
   output logic [YW-1:0]                        target_y,
   output logic [CHANNEL_NUMBER-1:0]            grant,
   output logic                                 wdog_err
);

   localparam int IW = $clog2(CHANNEL_NUMBER);
   localparam int BW = (MAX_PKT_BEATS > 0) ? $clog2(MAX_PKT_BEATS + 1) : 1;
   localparam bit WDOG_EN = (MAX_PKT_BEATS > 0);
   localparam logic [BW-1:0] CNT_LAST = BW'((MAX_PKT_BEATS > 0) ? MAX_PKT_BEATS - 1 : 0);
   localparam logic [BW-1:0] CNT_SAT  = '1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e                    state_q, state_d;
   logic [CHANNEL_NUMBER-1:0] grant_q, grant_d;
   logic [IW-1:0]             owner_q, owner_d;
   logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
   logic [XW-1:0]             target_x_q, target_x_d;
   logic [YW-1:0]             target_y_q, target_y_d;
   logic [BW-1:0]             beat_cnt_q, beat_cnt_d;
   logic                      wdog_err_q, wdog_err_d;

   logic                      win_found;
   logic [IW-1:0]             win_idx;
   logic [XW-1:0]             hdr_x;
   logic [YW-1:0]             hdr_y;

   logic [DATA_WIDTH-1:0]     own_tdata;
   logic                      own_valid;
   logic                      own_last;
   logic                      at_limit;

   // Winner selection. Round-robin scans starting just after the last
   // owner so the most recently served channel has the lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      if (ARB_MODE == 1) begin
         for (int i = CHANNEL_NUMBER - 1; i >= 0; i--) begin
            if (s_tvalid[i]) begin
               win_found = 1'b1;
               win_idx   = IW'(i);
            end
         end
      end else begin
         for (int k = 1; k <= CHANNEL_NUMBER; k++) begin
            if (!win_found && s_tvalid[(int'(rr_ptr_q) + k) % CHANNEL_NUMBER]) begin
               win_found = 1'b1;
               win_idx   = IW'((int'(rr_ptr_q) + k) % CHANNEL_NUMBER);
            end
         end
      end
   end

   assign hdr_x = s_tdata[int'(win_idx)*DATA_WIDTH +: XW];
   assign hdr_y = s_tdata[int'(win_idx)*DATA_WIDTH + XW +: YW];

   assign own_tdata = s_tdata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
   assign own_valid = s_tvalid[owner_q];
   assign own_last  = s_tlast[owner_q];

   // Depends only on the beat count, never on m_tready, so the forced
   // m_tlast is stable for as long as the beat waits for acceptance.
   assign at_limit = WDOG_EN && (beat_cnt_q == CNT_LAST);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      target_x_d = target_x_q;
      target_y_d = target_y_q;
      beat_cnt_d = beat_cnt_q;
      wdog_err_d = 1'b0;
      s_tready   = '0;
      m_tdata    = '0;
      m_tvalid   = 1'b0;
      m_tlast    = 1'b0;

      case (state_q)
         IDLE: begin
            // Arbitration cycle: nothing is consumed, the header is only peeked.
            if (win_found) begin
               state_d          = BUSY;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               owner_d          = win_idx;
               target_x_d       = hdr_x;
               target_y_d       = hdr_y;
               beat_cnt_d       = '0;
            end
         end

         BUSY: begin
            m_tdata           = own_tdata;
            m_tvalid          = own_valid;
            m_tlast           = own_last | at_limit;
            s_tready[owner_q] = m_tready;

            if (own_valid && m_tready) begin
               if (beat_cnt_q != CNT_SAT) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
               if (own_last || at_limit) begin
                  state_d    = IDLE;
                  grant_d    = '0;
                  wdog_err_d = !own_last;
                  if (ARB_MODE == 0) begin
                     rr_ptr_d = owner_q;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= IW'(CHANNEL_NUMBER - 1);
         target_x_q <= '0;
         target_y_q <= '0;
         beat_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         target_x_q <= target_x_d;
         target_y_q <= target_y_d;
         beat_cnt_q <= beat_cnt_d;
         wdog_err_q <= wdog_err_d;
      end
   end

   assign grant    = grant_q;
   assign target_x = target_x_q;
   assign target_y = target_y_q;
   assign wdog_err = wdog_err_q;

   grant_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
   grant_busy_a:   assert property (@(posedge clk) disable iff (!rst_n) ((grant_q != '0) == (state_q == BUSY)));

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb/tb_axis_packet_arbiter.sv - self-checking bench for axis_packet_arbiter

module tb_axis_packet_arbiter;

   localparam int N  = 5;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N*DW-1:0] tdata  [2];
   logic [N-1:0]    tvalid [2];
   logic [N-1:0]    tlast  [2];
   logic            mready [2];

   logic [N-1:0]  o0_sready, o1_sready;
   logic [DW-1:0] o0_mdata, o1_mdata;
   logic          o0_mvalid, o1_mvalid, o0_mlast, o1_mlast;
   logic [1:0]    o0_tx, o0_ty, o1_tx, o1_ty;
   logic [N-1:0]  o0_grant, o1_grant;
   logic          o0_wdog, o1_wdog;

   axis_packet_arbiter #(
      .CHANNEL_NUMBER(N), .DATA_WIDTH(DW), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
      .ARB_MODE(0), .MAX_PKT_BEATS(4)
   ) dut0 (
      .clk(clk), .rst_n(rst_n),
      .s_tdata(tdata[0]), .s_tvalid(tvalid[0]), .s_tlast(tlast[0]), .s_tready(o0_sready),
      .m_tdata(o0_mdata), .m_tvalid(o0_mvalid), .m_tlast(o0_mlast), .m_tready(mready[0]),
      .target_x(o0_tx), .target_y(o0_ty), .grant(o0_grant), .wdog_err(o0_wdog)
   );

   axis_packet_arbiter #(
      .CHANNEL_NUMBER(N), .DATA_WIDTH(DW), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
      .ARB_MODE(1), .MAX_PKT_BEATS(0)
   ) dut1 (
      .clk(clk), .rst_n(rst_n),
      .s_tdata(tdata[1]), .s_tvalid(tvalid[1]), .s_tlast(tlast[1]), .s_tready(o1_sready),
      .m_tdata(o1_mdata), .m_tvalid(o1_mvalid), .m_tlast(o1_mlast), .m_tready(mready[1]),
      .target_x(o1_tx), .target_y(o1_ty), .grant(o1_grant), .wdog_err(o1_wdog)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [4:0] g, input logic mv, input logic ml,
                                      input logic [4:0] sr, input logic [1:0] tx, input logic [1:0] ty,
                                      input logic wd, input logic [31:0] d);
      return {15'd0, g, mv, ml, sr, tx, ty, wd, (mv ? d : 32'd0)};
   endfunction

   function automatic logic [63:0] pack_out(input int k);
      if (k == 0) return mk(o0_grant, o0_mvalid, o0_mlast, o0_sready, o0_tx, o0_ty, o0_wdog, o0_mdata);
      return mk(o1_grant, o1_mvalid, o1_mlast, o1_sready, o1_tx, o1_ty, o1_wdog, o1_mdata);
   endfunction

   function automatic int idx_of(input logic [N-1:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return 0;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst;
      logic [4:0] v, l;
      logic [31:0] d;
      logic       r;
      logic [4:0] g;
      logic       mv, ml;
      logic [4:0] sr;
      logic [1:0] tx, ty;
      logic       wd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t V(input logic rst, input logic [4:0] v, input logic [4:0] l,
                              input logic [31:0] d, input logic r, input logic [4:0] g,
                              input logic mv, input logic ml, input logic [4:0] sr,
                              input logic [1:0] tx, input logic [1:0] ty, input logic wd);
      vec_t x;
      x.rst = rst; x.v = v; x.l = l; x.d = d; x.r = r; x.g = g;
      x.mv = mv; x.ml = ml; x.sr = sr; x.tx = tx; x.ty = ty; x.wd = wd;
      return x;
   endfunction

   // ---------------- traffic sources ----------------
   int  plen [2][N];
   int  pos  [2][N];
   int  seq  [2][N];
   bit  en   [2][N];
   bit  hs   [2][N];
   bit  rnd_mode  = 1'b0;
   int  fixed_len = 2;
   logic [N-1:0] g_s [2];

   task automatic advance_src();
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < N; c++) begin
            if (hs[k][c]) begin
               seq[k][c]++;
               pos[k][c]++;
               if (pos[k][c] >= plen[k][c]) begin
                  pos[k][c]  = 0;
                  plen[k][c] = rnd_mode ? int'($urandom_range(6, 1)) : fixed_len;
               end
            end
            // A presented beat stays put until it is accepted.
            if (!(tvalid[k][c] && !hs[k][c])) begin
               if (pos[k][c] != 0) tvalid[k][c] = rnd_mode ? ($urandom_range(3) != 0) : 1'b1;
               else                tvalid[k][c] = en[k][c];
               tdata[k][c*DW +: DW] = {4'(c), 12'(seq[k][c]), 12'h000, 4'($urandom_range(15))};
               tlast[k][c] = (pos[k][c] == plen[k][c] - 1);
            end
            hs[k][c] = 1'b0;
         end
      end
   endtask

   // ---------------- reference model ----------------
   int         m_own [2];
   int         m_rr  [2];
   int         m_cnt [2];
   logic [1:0] m_tx  [2];
   logic [1:0] m_ty  [2];
   bit         m_wd  [2];
   int         wd_seen = 0;

   task automatic model_check(input int k);
      int maxb, o, w, c2;
      bit lim, newwd;
      logic [63:0] exp;
      maxb = (k == 0) ? 4 : 0;
      o = m_own[k];
      if (o < 0) begin
         exp = mk(5'd0, 1'b0, 1'b0, 5'd0, m_tx[k], m_ty[k], m_wd[k], 32'd0);
      end else begin
         lim = (maxb > 0) && (m_cnt[k] == maxb - 1);
         exp = mk(5'(1 << o), tvalid[k][o], tlast[k][o] | lim, mready[k] ? 5'(1 << o) : 5'd0,
                  m_tx[k], m_ty[k], m_wd[k], tdata[k][o*DW +: DW]);
      end
      chk($sformatf("model_dut%0d", k), pack_out(k), exp);
      if (k == 0 && o0_wdog) wd_seen++;

      newwd = 1'b0;
      if (o < 0) begin
         w = -1;
         if (k == 1) begin
            for (int c = N - 1; c >= 0; c--) if (tvalid[k][c]) w = c;
         end else begin
            for (int j = 1; j <= N; j++) begin
               c2 = (m_rr[k] + j) % N;
               if (w < 0 && tvalid[k][c2]) w = c2;
            end
         end
         if (w >= 0) begin
            m_own[k] = w;
            m_tx[k]  = tdata[k][w*DW +: 2];
            m_ty[k]  = tdata[k][w*DW + 2 +: 2];
            m_cnt[k] = 0;
         end
      end else if (tvalid[k][o] && mready[k]) begin
         lim = (maxb > 0) && (m_cnt[k] == maxb - 1);
         m_cnt[k]++;
         if (tlast[k][o] || lim) begin
            newwd = !tlast[k][o];
            if (k == 0) m_rr[k] = o;
            m_own[k] = -1;
         end
      end
      m_wd[k] = newwd;
   endtask

   task automatic step(input bit model_on);
      logic [N-1:0] sr;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         g_s[k] = (k == 0) ? o0_grant : o1_grant;
         sr     = (k == 0) ? o0_sready : o1_sready;
         for (int c = 0; c < N; c++) hs[k][c] = tvalid[k][c] && sr[c];
         if (model_on) model_check(k);
      end
      @(posedge clk);
      #1;
      advance_src();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tvalid[k] = '0; tlast[k] = '0; tdata[k] = '0; mready[k] = 1'b0;
         for (int c = 0; c < N; c++) begin
            pos[k][c] = 0; seq[k][c] = 0; hs[k][c] = 1'b0; en[k][c] = 1'b0;
            plen[k][c] = rnd_mode ? int'($urandom_range(6, 1)) : fixed_len;
         end
         m_own[k] = -1; m_rr[k] = N - 1; m_cnt[k] = 0; m_tx[k] = '0; m_ty[k] = '0; m_wd[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      advance_src();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      vec_t r;
      int   gi;
      logic [N-1:0] prev;
      int   got[$];
      int   exp_rr[6];

      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tvalid[k] = '0; tlast[k] = '0; tdata[k] = '0; mready[k] = 1'b0;
      end

      //              rst  v         l         d       r  g         mv ml sr        tx ty wd
      tbl.push_back(V(0, 5'b00000, 5'b00000, 32'h00, 0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0));
      tbl.push_back(V(1, 5'b00100, 5'b00000, 32'h09, 1, 5'b00000, 0, 0, 5'b00000, 0, 0, 0));
      tbl.push_back(V(1, 5'b00100, 5'b00000, 32'h09, 1, 5'b00100, 1, 0, 5'b00100, 1, 2, 0));
      tbl.push_back(V(1, 5'b00100, 5'b00000, 32'hA1, 1, 5'b00100, 1, 0, 5'b00100, 1, 2, 0));
      tbl.push_back(V(1, 5'b00100, 5'b00100, 32'hA2, 1, 5'b00100, 1, 1, 5'b00100, 1, 2, 0));
      tbl.push_back(V(1, 5'b00000, 5'b00000, 32'h00, 1, 5'b00000, 0, 0, 5'b00000, 1, 2, 0));
      tbl.push_back(V(1, 5'b01000, 5'b00000, 32'h1F, 1, 5'b00000, 0, 0, 5'b00000, 1, 2, 0));
      tbl.push_back(V(1, 5'b01000, 5'b00000, 32'h1F, 1, 5'b01000, 1, 0, 5'b01000, 3, 3, 0));
      tbl.push_back(V(1, 5'b01000, 5'b00000, 32'hB1, 1, 5'b01000, 1, 0, 5'b01000, 3, 3, 0));
      tbl.push_back(V(1, 5'b01000, 5'b00000, 32'hB2, 1, 5'b01000, 1, 0, 5'b01000, 3, 3, 0));
      tbl.push_back(V(1, 5'b01000, 5'b00000, 32'hB3, 1, 5'b01000, 1, 1, 5'b01000, 3, 3, 0));
      tbl.push_back(V(1, 5'b01000, 5'b00000, 32'hB4, 1, 5'b00000, 0, 0, 5'b00000, 3, 3, 1));
      tbl.push_back(V(1, 5'b01000, 5'b00000, 32'hB4, 1, 5'b01000, 1, 0, 5'b01000, 0, 1, 0));
      tbl.push_back(V(1, 5'b01000, 5'b01000, 32'hB5, 1, 5'b01000, 1, 1, 5'b01000, 0, 1, 0));
      tbl.push_back(V(1, 5'b00000, 5'b00000, 32'h00, 1, 5'b00000, 0, 0, 5'b00000, 0, 1, 0));
      tbl.push_back(V(0, 5'b00000, 5'b00000, 32'h00, 1, 5'b00000, 0, 0, 5'b00000, 0, 0, 0));
      tbl.push_back(V(1, 5'b10001, 5'b00000, 32'h05, 1, 5'b00000, 0, 0, 5'b00000, 0, 0, 0));
      tbl.push_back(V(1, 5'b10001, 5'b00000, 32'h05, 1, 5'b00001, 1, 0, 5'b00001, 1, 1, 0));
      tbl.push_back(V(1, 5'b10001, 5'b00000, 32'hC1, 0, 5'b00001, 1, 0, 5'b00000, 1, 1, 0));
      tbl.push_back(V(1, 5'b10001, 5'b00000, 32'hC1, 0, 5'b00001, 1, 0, 5'b00000, 1, 1, 0));
      tbl.push_back(V(1, 5'b10001, 5'b00000, 32'hC1, 1, 5'b00001, 1, 0, 5'b00001, 1, 1, 0));
      tbl.push_back(V(1, 5'b10001, 5'b00000, 32'hC2, 1, 5'b00001, 1, 0, 5'b00001, 1, 1, 0));
      tbl.push_back(V(1, 5'b10001, 5'b00001, 32'hC3, 1, 5'b00001, 1, 1, 5'b00001, 1, 1, 0));
      tbl.push_back(V(1, 5'b10000, 5'b00000, 32'h06, 1, 5'b00000, 0, 0, 5'b00000, 1, 1, 0));
      tbl.push_back(V(1, 5'b10000, 5'b00000, 32'h06, 1, 5'b10000, 1, 0, 5'b10000, 2, 1, 0));
      tbl.push_back(V(1, 5'b10000, 5'b10000, 32'h07, 1, 5'b10000, 1, 1, 5'b10000, 2, 1, 0));
      tbl.push_back(V(1, 5'b00000, 5'b00000, 32'h00, 1, 5'b00000, 0, 0, 5'b00000, 2, 1, 0));
      tbl.push_back(V(1, 5'b00010, 5'b00000, 32'h0D, 1, 5'b00000, 0, 0, 5'b00000, 2, 1, 0));
      tbl.push_back(V(1, 5'b00010, 5'b00000, 32'h0D, 1, 5'b00010, 1, 0, 5'b00010, 1, 3, 0));
      tbl.push_back(V(0, 5'b00010, 5'b00000, 32'hD1, 1, 5'b00000, 0, 0, 5'b00000, 0, 0, 0));
      tbl.push_back(V(1, 5'b00011, 5'b00000, 32'h0E, 1, 5'b00000, 0, 0, 5'b00000, 0, 0, 0));
      tbl.push_back(V(1, 5'b00011, 5'b00000, 32'h0E, 1, 5'b00001, 1, 0, 5'b00001, 2, 3, 0));
      tbl.push_back(V(1, 5'b00011, 5'b00011, 32'h0E, 1, 5'b00001, 1, 1, 5'b00001, 2, 3, 0));
      tbl.push_back(V(1, 5'b00010, 5'b00010, 32'h0E, 1, 5'b00000, 0, 0, 5'b00000, 2, 3, 0));
      tbl.push_back(V(1, 5'b00010, 5'b00010, 32'h0E, 1, 5'b00010, 1, 1, 5'b00010, 2, 3, 0));
      tbl.push_back(V(1, 5'b00000, 5'b00000, 32'h00, 1, 5'b00000, 0, 0, 5'b00000, 2, 3, 0));

      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         r = tbl[i];
         rst_n     = r.rst;
         tvalid[0] = r.v;
         tlast[0]  = r.l;
         mready[0] = r.r;
         for (int c = 0; c < N; c++) tdata[0][c*DW +: DW] = r.d ^ (32'(c) << 24);
         gi = idx_of(r.g);
         @(negedge clk);
         chk($sformatf("vec%0d", i), pack_out(0),
             mk(r.g, r.mv, r.ml, r.sr, r.tx, r.ty, r.wd, r.d ^ (32'(gi) << 24)));
         @(posedge clk);
         #1;
      end

      // Round-robin fairness: every channel always has a 2-beat packet ready.
      rnd_mode = 1'b0; fixed_len = 2;
      do_reset();
      mready[0] = 1'b1;
      for (int c = 0; c < N; c++) en[0][c] = 1'b1;
      advance_src();
      prev = '0;
      got.delete();
      for (int t = 0; t < 80 && got.size() < 6; t++) begin
         step(1'b0);
         if (g_s[0] != '0 && prev == '0) got.push_back(idx_of(g_s[0]));
         prev = g_s[0];
      end
      exp_rr = '{0, 1, 2, 3, 4, 0};
      for (int i = 0; i < 6; i++)
         chk($sformatf("rr_order%0d", i), 64'(got.size() > i ? got[i] : 99), 64'(exp_rr[i]));

      // Fixed priority: ch1 wins while it keeps requesting, ch3 once it stops.
      do_reset();
      mready[1] = 1'b1;
      en[1][1] = 1'b1;
      en[1][3] = 1'b1;
      advance_src();
      prev = '0;
      got.delete();
      for (int t = 0; t < 80 && got.size() < 5; t++) begin
         step(1'b0);
         if (g_s[1] != '0 && prev == '0) begin
            got.push_back(idx_of(g_s[1]));
            if (got.size() == 4) en[1][1] = 1'b0;
         end
         prev = g_s[1];
      end
      for (int i = 0; i < 5; i++)
         chk($sformatf("fp_grant%0d", i), 64'(got.size() > i ? got[i] : 99), 64'((i < 4) ? 1 : 3));

      // Randomised traffic on both instances against the reference model.
      rnd_mode = 1'b1;
      do_reset();
      for (int t = 0; t < 2500; t++) begin
         for (int k = 0; k < 2; k++) begin
            mready[k] = ($urandom_range(3) != 0);
            for (int c = 0; c < N; c++) en[k][c] = ($urandom_range(2) != 0);
         end
         step(1'b1);
      end
      chk("wdog_seen", 64'(wd_seen > 0), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Generalised N-input to 1-output AXI-Stream arbiter for the router output port.
- Grants ownership per packet and holds the grant until the TLAST beat.
- Latches the destination coordinates from the header flit.
- Round-robin or fixed-priority policy, selected by parameter, with a per-packet beat watchdog that forces release of runaway packets.

Parameters:
- CHANNEL_NUMBER, 5, number of input channels (2..16).
- DATA_WIDTH, 32, TDATA width.
- MAX_ROUTERS_X, 4, mesh X size; XW = $clog2(MAX_ROUTERS_X).
- MAX_ROUTERS_Y, 4, mesh Y size; YW = $clog2(MAX_ROUTERS_Y).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- MAX_PKT_BEATS, 64, watchdog limit in beats per packet; 0 disables the watchdog.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- s_tdata, input, CHANNEL_NUMBER*DATA_WIDTH, per-channel data; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid, input, CHANNEL_NUMBER, per-channel valid.
- s_tlast, input, CHANNEL_NUMBER, per-channel last.
- s_tready, output, CHANNEL_NUMBER, per-channel ready.
- m_tdata, output, DATA_WIDTH, muxed data.
- m_tvalid, output, 1, muxed valid.
- m_tlast, output, 1, muxed last (forced to 1 on the watchdog beat).
- m_tready, input, 1, downstream ready.
- target_x, output, XW, header X of the current packet.
- target_y, output, YW, header Y of the current packet.
- grant, output, CHANNEL_NUMBER, one-hot owner; 0 when idle.
- wdog_err, output, 1, one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values: state = IDLE, grant = 0, rr_ptr = CHANNEL_NUMBER-1, target_x = 0, target_y = 0, beat_cnt = 0, wdog_err = 0. All s_tready = 0 and m_tvalid = 0.
- Header format of the first beat: target_x = TDATA[XW-1:0], target_y = TDATA[XW+YW-1:XW].

FSM: IDLE.
- m_tvalid = 0 and s_tready = 0.
- If any s_tvalid is high, pick winner w:
  - ARB_MODE 0: first valid channel scanning rr_ptr+1, rr_ptr+2, ..., with wrap modulo CHANNEL_NUMBER.
  - ARB_MODE 1: lowest valid index.
- On the next edge: grant <= onehot(w), target_x/target_y <= header fields of s_tdata[w], beat_cnt <= 0, state <= BUSY.
- No input is consumed in IDLE. Arbitration costs one bubble cycle per packet.

FSM: BUSY (owner g).
- Combinational path: m_tdata = s_tdata[g], m_tvalid = s_tvalid[g], m_tlast = s_tlast[g]. s_tready[g] = m_tready; all other s_tready = 0.
- On each handshake (s_tvalid[g] && m_tready), beat_cnt increments.
- Handshake with s_tlast[g] = 1: state <= IDLE, grant <= 0, rr_ptr <= g (ARB_MODE 0 only).
- Watchdog (MAX_PKT_BEATS > 0): on the handshake where beat_cnt == MAX_PKT_BEATS-1 and s_tlast[g] = 0:
  - m_tlast is driven to 1 on that beat.
  - wdog_err pulses on the next cycle.
  - The block releases exactly as for a TLAST beat.
  - The remaining beats of that packet re-arbitrate as a new packet.
- target_x/target_y are stable for the whole BUSY period.
- s_tvalid deasserting mid-packet: the block stays BUSY with m_tvalid = 0 and does not re-arbitrate.
- A single-beat packet (tlast on the header beat) is legal and returns to IDLE after one beat.
- Requests arriving on non-granted channels while BUSY are ignored until the next IDLE cycle.
- No beat is ever duplicated or dropped. AXI-Stream rule: valid must not depend on ready.
- beat_cnt width is $clog2(MAX_PKT_BEATS+1); no wrap within a packet.
- Reset asserted mid-packet: outputs return to reset values immediately. The partial packet is not resumed.

Test Plan:
- Single packet: ch2 sends 3 beats, header 0x0000_0009 (x = 1, y = 2), m_tready = 1 -> grant = 0b00100 after 1 bubble, target_x = 1, target_y = 2, 3 beats out in order with m_tlast on beat 3, back to IDLE.
- RR fairness: ARB_MODE 0, all 5 channels continuously send 2-beat packets -> grant order 0, 1, 2, 3, 4, 0, with no channel granted twice before the others.
- Fixed priority: ARB_MODE 1, ch1 and ch3 both continuously valid -> ch1 always wins. Once ch1 stops, ch3 is granted at the next IDLE.
- Backpressure and hold: m_tready toggles 1, 0, 0, 1 during a 4-beat ch0 packet while ch4 is valid -> no interleaving, ch0 completes, then ch4 is granted.
- Watchdog: MAX_PKT_BEATS = 4, ch3 sends 6 beats with no tlast -> beat 4 leaves with m_tlast = 1, wdog_err pulses once, beats 5-6 re-arbitrate as a new packet.
- Reset mid-packet: rst_n low during beat 2 of ch1 -> grant = 0, m_tvalid = 0, s_tready = 0 immediately. After release, the block resumes arbitration from rr_ptr = 4.
